imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares one single-port synchronous instruction memory (`imem`) between NUM_CORES processor cores and one program loader.
- After reset the block is in LOAD mode. Only the loader may write program bytes.
- On `ld_done` it enters RUN mode, releases the cores and arbitrates their fetch requests round-robin, one access per cycle.
- Sits between the cores' fetch stages and the memory: `mem_*` ports connect to the memory's clock/wren/data/address/q.

Parameters:
- NUM_CORES, 4, number of fetching cores (2..8).
- data_width, 8, instruction word width.
- address_width, 8, memory address width (256 locations).

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ld_req`  in  1  loader write request (LOAD mode only).
- `ld_addr`  in  address_width  loader write address.
- `ld_data`  in  data_width  loader write data.
- `ld_ack`  out  1  write accepted this cycle.
- `ld_done`  in  1  single-cycle pulse: program fully loaded.
- `core_run`  out  1  high in RUN mode; cores held stalled while low.
- `req`  in  NUM_CORES  per-core fetch request, level, held until granted.
- `addr`  in  NUM_CORES*address_width  flattened fetch addresses; core i occupies bits [i*address_width +: address_width].
- `gnt`  out  NUM_CORES  one-hot, combinational: core's request accepted this cycle.
- `rvalid`  out  NUM_CORES  one-hot, registered: `rdata` belongs to this core.
- `rdata`  out  data_width  fetched instruction, equal to `mem_q`.
- `mem_wren`  out  1  memory write enable.
- `mem_data`  out  data_width  memory write data.
- `mem_address`  out  address_width  memory address.
- `mem_q`  in  data_width  memory read data; 1-cycle registered latency.

Behaviour:
- FSM states: LOAD (reset state) and RUN.
  - LOAD -> RUN on `ld_done`=1 at a clock edge.
  - RUN has no exit except `reset`.
  - `ld_done` in RUN is ignored.
- Reset values: state=LOAD, rr_ptr=0, `rvalid`=0, `core_run`=0. Consequently `gnt`=0, `ld_ack`=0, `mem_wren`=0, `mem_address`=0, `mem_data`=0.
- LOAD mode:
  - `ld_req`=1 -> `mem_wren`=1, `mem_address`=`ld_addr`, `mem_data`=`ld_data`, `ld_ack`=1, all combinational in the same cycle.
  - One write per cycle; back-to-back writes allowed.
  - `req` is ignored and `gnt`=0.
  - `ld_req` and `ld_done` in the same cycle: the write is performed, then the state changes.
- RUN mode:
  - `ld_req` is ignored (`ld_ack`=0, `mem_wren`=0). `mem_data`=0.
  - Round-robin arbitration: search `req` starting at index rr_ptr, wrapping modulo NUM_CORES. The first set bit k gets `gnt`[k]=1 and `mem_address`=`addr`[k].
  - On a grant, rr_ptr <= (k+1) mod NUM_CORES. With no request, rr_ptr holds and `mem_address` holds its last value (no grant).
  - Latency: grant in cycle t -> `rvalid`[k]=1 in cycle t+1 with `rdata`=`mem_q`=mem[`addr`[k]].
  - Read-only, so there is no hazard.
  - A core may hold `req` high continuously. It is re-granted only after the other requesters have each had a turn.
  - Worst-case wait is NUM_CORES-1 cycles.
- `rvalid` is a register loaded with `gnt` each cycle. It is zero in LOAD mode and after any idle cycle.
- `reset` asserted mid-fetch:
  - pending `rvalid` cleared immediately (asynchronously);
  - state returns to LOAD and the memory contents are untouched;
  - the cores must re-issue requests.
- `addr` width arithmetic: no wrap handling is needed in this block; addresses pass through unchanged.

Decomposition:
- Shared package:
  - state encoding localparams LOAD=1'b0, RUN=1'b1;
  - default widths (data_width=8, address_width=8) used by the memory, cores and arbiter.
- One natural sub-module: `rr_arbiter` (NUM_CORES). Inputs: `req`, `ptr`. Outputs: one-hot `gnt` and binary `idx`; purely combinational.
- The top level holds the FSM, rr_ptr, the `rvalid` register and the `mem_*` muxing.

Test Plan:
1. Reset, then `ld_req` with (addr=0,data=2), (1,3), (2,1) on consecutive cycles, then `ld_done` -> `ld_ack`=1 each cycle, `mem_wren` pulses three times, `core_run` rises the cycle after `ld_done`. A fetch of address 1 by core 0 then returns `rdata`=3 with `rvalid`=4'b0001 one cycle after grant.
2. RUN, `req`=4'b1111 held for 8 cycles with `addr`[i]=i -> `gnt` sequence 0001,0010,0100,1000,0001,... and `rvalid` follows one cycle later with `rdata`=mem[i].
3. RUN, only core 2 requesting continuously -> `gnt`=4'b0100 every cycle. Core 0 then raises `req` -> it is granted within 1 cycle, after which core 2 resumes alternating.
4. LOAD, `req`=4'b1111 with `ld_req`=0 -> `gnt`=0, `rvalid`=0. In RUN, `ld_req`=1 -> `ld_ack`=0, `mem_wren`=0.
5. `reset` asserted in the cycle after a grant to core 1 -> `rvalid` goes to 0 without waiting for a clock edge, `core_run`=0, rr_ptr=0. After a new `ld_done`, core 0 wins first with `req`=4'b0011.
6. `ld_req` and `ld_done` in the same cycle (addr=5,data=9) -> the write occurs. A later core fetch of address 5 returns 9.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: state encoding and default widths shared by the
// instruction memory, the cores and the arbiter.
package imem_arbiter_pkg;
   typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;
   localparam int DATA_WIDTH    = 8;
   localparam int ADDRESS_WIDTH = 8;
endpackage

// File: rtl/imem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching req upward from ptr
// with wrap-around; returns a one-hot grant and the winner's index.
module rr_arbiter #(
   parameter int NUM_CORES = 4
) (
   input  logic [NUM_CORES-1:0]         req,
   input  logic [$clog2(NUM_CORES)-1:0] ptr,
   output logic [NUM_CORES-1:0]         gnt,
   output logic [$clog2(NUM_CORES)-1:0] idx
);
   localparam int IW = $clog2(NUM_CORES);
   logic          found;
   logic [IW-1:0] j;
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         j = IW'((int'(ptr) + i) % NUM_CORES);
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: lets a program loader fill a single-port instruction memory,
// then shares that memory round-robin between NUM_CORES fetching cores.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int NUM_CORES     = 4,
   parameter int data_width    = DATA_WIDTH,
   parameter int address_width = ADDRESS_WIDTH
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               ld_req,
   input  logic [address_width-1:0]           ld_addr,
   input  logic [data_width-1:0]              ld_data,
   output logic                               ld_ack,
   input  logic                               ld_done,
   output logic                               core_run,
   input  logic [NUM_CORES-1:0]               req,
   input  logic [NUM_CORES*address_width-1:0] addr,
   output logic [NUM_CORES-1:0]               gnt,
   output logic [NUM_CORES-1:0]               rvalid,
   output logic [data_width-1:0]              rdata,
   output logic                               mem_wren,
   output logic [data_width-1:0]              mem_data,
   output logic [address_width-1:0]           mem_address,
   input  logic [data_width-1:0]              mem_q
);
   localparam int IW = $clog2(NUM_CORES);
   state_t                   state;
   logic                     run;
   logic [IW-1:0]            rr_ptr, idx;
   logic [NUM_CORES-1:0]     arb_gnt;
   logic [address_width-1:0] sel_addr, last_addr;
   rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
      .req (req),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (idx)
   );
   assign run         = state == RUN;
   assign core_run    = run;
   assign sel_addr    = addr[int'(idx)*address_width +: address_width];
   assign gnt         = run ? arb_gnt : '0;
   assign ld_ack      = !run && ld_req;
   assign mem_wren    = ld_ack;
   assign mem_data    = ld_ack ? ld_data : '0;
   // An idle RUN cycle keeps presenting the last fetched address.
   assign mem_address = ld_ack ? ld_addr : |gnt ? sel_addr : run ? last_addr : '0;
   assign rdata       = mem_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= LOAD;
         rr_ptr    <= '0;
         rvalid    <= '0;
         last_addr <= '0;
      end else begin
         rvalid <= gnt;
         if (!run && ld_done) state <= RUN;
         if (|gnt) begin
            rr_ptr    <= (int'(idx) == NUM_CORES - 1) ? '0 : idx + 1'b1;
            last_addr <= sel_addr;
         end
      end
   end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized and directed scenarios against a queue-free
// behavioural model of load/run arbitration and a bench-side memory.
module tb_imem_arbiter;
   localparam int N = 4, DW = 8, AW = 8;
   logic            clock = 1'b0, reset = 1'b1;
   logic            ld_req = 1'b0, ld_done = 1'b0, ld_ack, core_run, mem_wren;
   logic [AW-1:0]   ld_addr = '0, mem_address;
   logic [DW-1:0]   ld_data = '0, rdata, mem_data, mem_q;
   logic [N-1:0]    req = '0, gnt, rvalid;
   logic [N*AW-1:0] addr = '0;
   logic [DW-1:0]   mem [256];
   logic [DW-1:0]   ref_mem [256];
   int              n_run = 0, n_fail = 0;
   bit              m_run, n_run_st;
   int              m_ptr, n_ptr, n_pend;
   logic [AW-1:0]   m_last, n_last, n_pend_addr;
   logic [N-1:0]    e_gnt, e_rvalid;
   logic            e_ack, e_av, e_run;
   logic [AW-1:0]   e_addr;
   logic [DW-1:0]   e_data, e_rdata;

   always #5 clock = ~clock;

   imem_arbiter dut (
      .clock(clock), .reset(reset), .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ack(ld_ack), .ld_done(ld_done), .core_run(core_run), .req(req), .addr(addr),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_wren(mem_wren), .mem_data(mem_data),
      .mem_address(mem_address), .mem_q(mem_q)
   );

   always @(posedge clock) begin
      if (mem_wren) mem[mem_address] <= mem_data;
      mem_q <= mem[mem_address];
   end

   // Model: the first requester at or after the pointer (mod N) wins in RUN.
   task automatic drive(input logic lr, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                        input logic dn, input logic [N-1:0] rq, input logic [N*AW-1:0] ad);
      int k;
      ld_req = lr; ld_addr = la; ld_data = ldd; ld_done = dn; req = rq; addr = ad;
      k = -1;
      if (m_run)
         for (int o = 0; o < N; o++)
            if (k < 0 && rq[(m_ptr + o) % N]) k = (m_ptr + o) % N;
      e_gnt = '0;
      if (k >= 0) e_gnt[k] = 1'b1;
      e_ack  = !m_run && lr;
      e_data = e_ack ? ldd : '0;
      e_av   = e_ack || m_run;
      e_addr = e_ack ? la : (k >= 0) ? ad[k*AW +: AW] : m_last;
      if (e_ack) ref_mem[la] = ldd;
      n_pend      = k;
      n_pend_addr = (k >= 0) ? ad[k*AW +: AW] : '0;
      n_ptr       = (k >= 0) ? (k + 1) % N : m_ptr;
      n_last      = (k >= 0) ? ad[k*AW +: AW] : m_last;
      n_run_st    = m_run || dn;
      #4;
   endtask

   task automatic advance();
      @(posedge clock); #1;
      m_run = n_run_st; m_ptr = n_ptr; m_last = n_last; e_run = m_run;
      e_rvalid = '0;
      if (n_pend >= 0) e_rvalid[n_pend] = 1'b1;
      e_rdata = ref_mem[n_pend_addr];
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_ptr = 0; m_last = '0; e_run = 1'b0; e_rvalid = '0; n_pend = -1;
   endtask

   task automatic do_reset();
      reset = 1'b1; ld_req = 1'b0; ld_done = 1'b0; req = '0; addr = '0;
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1; req = '1;
      @(posedge clock); #1;
      n_run++;
      if ({gnt, ld_ack, mem_wren, mem_address, mem_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_comb: gnt=%b ack=%b wren=%b addr=%h data=%h, all must be 0", gnt, ld_ack, mem_wren, mem_address, mem_data);
      end
      n_run++;
      if (rvalid !== '0 || core_run !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_regs: rvalid=%b core_run=%b, both must be 0", rvalid, core_run);
      end
      @(posedge clock); #1;
      reset = 1'b0; req = '0;
      model_reset();
   endtask

   task automatic test_load_fetch();
      for (int i = 0; i < 6; i++) begin
         if (i < 3) drive(1'b1, AW'(i), (i == 0) ? 8'd2 : (i == 1) ? 8'd3 : 8'd1, 1'b0, 4'b1111, {$urandom});
         else if (i == 3) drive(1'b0, '0, '0, 1'b1, 4'b1111, {$urandom});
         else if (i == 4) drive(1'b0, '0, '0, 1'b0, 4'b0001, 32'h0000_0001);
         else drive(1'b0, '0, '0, 1'b0, 4'b0000, {$urandom});
         n_run++;
         if (gnt !== e_gnt || ld_ack !== e_ack || mem_wren !== e_ack || mem_data !== e_data || (e_av && mem_address !== e_addr)) begin
            n_fail++;
            $display("FAIL load_fetch comb cyc%0d: gnt=%b ack=%b wren=%b addr=%h data=%h exp gnt=%b ack=%b addr=%h data=%h",
                     i, gnt, ld_ack, mem_wren, mem_address, mem_data, e_gnt, e_ack, e_addr, e_data);
         end
         advance();
         n_run++;
         if (rvalid !== e_rvalid || core_run !== e_run || (|e_rvalid && rdata !== e_rdata)) begin
            n_fail++;
            $display("FAIL load_fetch regs cyc%0d: rvalid=%b run=%b rdata=%h exp rvalid=%b run=%b rdata=%h",
                     i, rvalid, core_run, rdata, e_rvalid, e_run, e_rdata);
         end
         if (i == 4) begin
            n_run++;
            if (rvalid !== 4'b0001 || rdata !== 8'd3) begin
               n_fail++;
               $display("FAIL load_fetch addr1: rvalid=%b rdata=%h exp 0001 03", rvalid, rdata);
            end
         end
      end
   endtask

   task automatic test_reset_midfetch();
      drive(1'b0, '0, '0, 1'b0, 4'b0010, {8'd0, 8'd0, 8'd2, 8'd0});
      n_run++;
      if (gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL midfetch_gnt: gnt=%b exp 0010", gnt);
      end
      advance();
      n_run++;
      if (rvalid !== 4'b0010 || rdata !== 8'd1) begin
         n_fail++;
         $display("FAIL midfetch_rvalid: rvalid=%b rdata=%h exp 0010 01", rvalid, rdata);
      end
      #2 reset = 1'b1;
      #1;
      n_run++;
      if (rvalid !== '0 || core_run !== 1'b0 || gnt !== '0) begin
         n_fail++;
         $display("FAIL midfetch_async: rvalid=%b run=%b gnt=%b exp 0000 0 0000", rvalid, core_run, gnt);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, '0, i == 0, (i < 2) ? 4'b0011 : 4'b0000, {8'd0, 8'd0, 8'd1, 8'd0});
         n_run++;
         if (gnt !== ((i == 1) ? 4'b0001 : 4'b0000)) begin
            n_fail++;
            $display("FAIL midfetch_restart cyc%0d: gnt=%b", i, gnt);
         end
         advance();
         n_run++;
         if (rvalid !== e_rvalid || core_run !== e_run || (|e_rvalid && rdata !== e_rdata)) begin
            n_fail++;
            $display("FAIL midfetch_restart regs cyc%0d: rvalid=%b run=%b rdata=%h exp rvalid=%b run=%b rdata=%h",
                     i, rvalid, core_run, rdata, e_rvalid, e_run, e_rdata);
         end
      end
   endtask

   task automatic test_load_all();
      int a = 0;
      do_reset();
      while (a < 256) begin
         logic lr;
         lr = (a != 5) && ($urandom_range(3) != 0);
         drive(lr, AW'(a), DW'($urandom), 1'b0, N'($urandom), {$urandom});
         n_run++;
         if (gnt !== e_gnt || ld_ack !== e_ack || mem_wren !== e_ack || mem_data !== e_data || (e_av && mem_address !== e_addr)) begin
            n_fail++;
            $display("FAIL load_all comb a=%0d: gnt=%b ack=%b wren=%b addr=%h data=%h exp gnt=%b ack=%b addr=%h data=%h",
                     a, gnt, ld_ack, mem_wren, mem_address, mem_data, e_gnt, e_ack, e_addr, e_data);
         end
         advance();
         n_run++;
         if (rvalid !== e_rvalid || core_run !== e_run) begin
            n_fail++;
            $display("FAIL load_all regs a=%0d: rvalid=%b run=%b exp rvalid=%b run=%b", a, rvalid, core_run, e_rvalid, e_run);
         end
         if (lr || a == 5) a++;
      end
      drive(1'b1, 8'd5, 8'd9, 1'b1, 4'b1111, {$urandom});
      n_run++;
      if (ld_ack !== 1'b1 || mem_wren !== 1'b1 || mem_address !== 8'd5 || mem_data !== 8'd9 || gnt !== '0) begin
         n_fail++;
         $display("FAIL write_with_done: ack=%b wren=%b addr=%h data=%h gnt=%b exp 1 1 05 09 0000",
                  ld_ack, mem_wren, mem_address, mem_data, gnt);
      end
      advance();
      n_run++;
      if (core_run !== 1'b1) begin
         n_fail++;
         $display("FAIL write_with_done run: core_run=%b exp 1", core_run);
      end
      drive(1'b0, '0, '0, 1'b0, 4'b1000, {8'd5, 24'd0});
      advance();
      n_run++;
      if (rvalid !== 4'b1000 || rdata !== 8'd9) begin
         n_fail++;
         $display("FAIL fetch_addr5: rvalid=%b rdata=%h exp 1000 09", rvalid, rdata);
      end
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, '0, '0, 1'b0, 4'b1111, {8'd3, 8'd2, 8'd1, 8'd0});
         n_run++;
         if (gnt !== (4'b0001 << (i % 4)) || gnt !== e_gnt || mem_address !== AW'(i % 4)) begin
            n_fail++;
            $display("FAIL round_robin cyc%0d: gnt=%b addr=%h exp gnt=%b addr=%0d", i, gnt, mem_address, 4'b0001 << (i % 4), i % 4);
         end
         advance();
         n_run++;
         if (rvalid !== e_rvalid || rdata !== e_rdata) begin
            n_fail++;
            $display("FAIL round_robin regs cyc%0d: rvalid=%b rdata=%h exp rvalid=%b rdata=%h", i, rvalid, rdata, e_rvalid, e_rdata);
         end
      end
   endtask

   task automatic test_starve();
      for (int i = 0; i < 8; i++) begin
         logic [N-1:0] want;
         want = (i < 4) ? 4'b0100 : ((i % 2) == 0) ? 4'b0001 : 4'b0100;
         drive(1'b0, '0, '0, 1'b0, (i < 4) ? 4'b0100 : 4'b0101, {$urandom});
         n_run++;
         if (gnt !== want || gnt !== e_gnt) begin
            n_fail++;
            $display("FAIL starve cyc%0d: gnt=%b exp %b", i, gnt, want);
         end
         advance();
         n_run++;
         if (rvalid !== e_rvalid || rdata !== e_rdata) begin
            n_fail++;
            $display("FAIL starve regs cyc%0d: rvalid=%b rdata=%h exp rvalid=%b rdata=%h", i, rvalid, rdata, e_rvalid, e_rdata);
         end
      end
   endtask

   task automatic test_run_ignores_load();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, AW'($urandom), DW'($urandom), 1'b1, 4'b0000, {$urandom});
         n_run++;
         if (ld_ack !== 1'b0 || mem_wren !== 1'b0 || mem_data !== '0 || gnt !== '0 || mem_address !== e_addr) begin
            n_fail++;
            $display("FAIL run_ignores_load cyc%0d: ack=%b wren=%b data=%h gnt=%b addr=%h exp 0 0 00 0000 %h",
                     i, ld_ack, mem_wren, mem_data, gnt, mem_address, e_addr);
         end
         advance();
         n_run++;
         if (core_run !== 1'b1 || rvalid !== '0) begin
            n_fail++;
            $display("FAIL run_ignores_load regs cyc%0d: run=%b rvalid=%b exp 1 0000", i, core_run, rvalid);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(1)), AW'($urandom), DW'($urandom), 1'($urandom_range(1)), N'($urandom), {$urandom});
         n_run++;
         if (gnt !== e_gnt || ld_ack !== e_ack || mem_wren !== e_ack || mem_data !== e_data || (e_av && mem_address !== e_addr)) begin
            n_fail++;
            $display("FAIL random comb cyc%0d: gnt=%b ack=%b wren=%b addr=%h data=%h exp gnt=%b ack=%b addr=%h data=%h",
                     i, gnt, ld_ack, mem_wren, mem_address, mem_data, e_gnt, e_ack, e_addr, e_data);
         end
         advance();
         n_run++;
         if (rvalid !== e_rvalid || core_run !== e_run || (|e_rvalid && rdata !== e_rdata)) begin
            n_fail++;
            $display("FAIL random regs cyc%0d: rvalid=%b run=%b rdata=%h exp rvalid=%b run=%b rdata=%h",
                     i, rvalid, core_run, rdata, e_rvalid, e_run, e_rdata);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_fetch();
      test_reset_midfetch();
      test_load_all();
      test_round_robin();
      test_starve();
      test_run_ignores_load();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
